// File: rtl/resta_pkg.sv
// resta_pkg: shared width default and status-flag layout for the subtraction unit.
package resta_pkg;
    localparam int RESTA_WIDTH_DEFAULT = 4;
    typedef struct packed {
        logic borrow;
        logic zero;
        logic neg;
        logic ovf;
    } resta_flags_t;
    localparam resta_flags_t RESTA_FLAGS_RST = '{borrow: 1'b0, zero: 1'b1, neg: 1'b0, ovf: 1'b0};
endpackage

// File: rtl/resta_core.sv
// resta_core: combinational ripple-borrow subtractor built from full-subtractor cells.
module resta_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);
    logic [WIDTH:0] br;
    assign br[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]  = a[i] ^ b[i] ^ br[i];
        assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    assign borrow = br[WIDTH];
endmodule

// File: rtl/resta_sync.sv
// resta_sync: registered two's-complement subtractor with borrow/zero/neg/ovf flags.
module resta_sync
    import resta_pkg::*;
#(
    parameter int WIDTH = RESTA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             out_valid
);
    logic [WIDTH-1:0] diff, s_d, s_q;
    logic             bw, ovf_c, valid_d, valid_q;
    resta_flags_t     flags_d, flags_q;
    resta_core #(.WIDTH(WIDTH)) u_core (.a(a), .b(b), .diff(diff), .borrow(bw));
    assign ovf_c = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    always_comb begin
        s_d     = in_valid ? diff : s_q;
        flags_d = in_valid ? resta_flags_t'{bw, ~|diff, diff[WIDTH-1], ovf_c} : flags_q;
        valid_d = in_valid;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q     <= '0;
            flags_q <= RESTA_FLAGS_RST;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end
    assign s         = s_q;
    assign borrow    = flags_q.borrow;
    assign zero      = flags_q.zero;
    assign neg       = flags_q.neg;
    assign ovf       = flags_q.ovf;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_resta_sync.sv
// tb_resta_sync: directed and random stimulus against an integer-arithmetic reference model.
module tb_resta_sync;
    localparam int W = 4;
    localparam int M = 1 << W;
    logic         clk = 1'b0;
    logic         rst, in_valid;
    logic [W-1:0] a, b, s;
    logic         borrow, zero, neg, ovf, out_valid;
    int           checks = 0;
    int           errors = 0;
    int           m_s = 0, m_borrow = 0, m_zero = 1, m_neg = 0, m_ovf = 0, m_valid = 0;

    resta_sync #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
        .s(s), .borrow(borrow), .zero(zero), .neg(neg), .ovf(ovf), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Drive one cycle, advance the model by the edge, then compare every output.
    task automatic step(input logic r, input logic v, input int av, input int bv, input string tag);
        int d, sd;
        rst = r; in_valid = v; a = W'(av); b = W'(bv);
        @(posedge clk);
        #1;
        if (r) begin
            m_s = 0; m_borrow = 0; m_zero = 1; m_neg = 0; m_ovf = 0; m_valid = 0;
        end else if (v) begin
            d = av - bv;
            m_borrow = (av < bv) ? 1 : 0;
            m_s = (d < 0) ? d + M : d;
            m_zero = (m_s == 0) ? 1 : 0;
            m_neg = (m_s >= M / 2) ? 1 : 0;
            sd = to_signed(av) - to_signed(bv);
            m_ovf = (sd > M / 2 - 1 || sd < -(M / 2)) ? 1 : 0;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        chk({tag, ".s"}, int'(s), m_s);
        chk({tag, ".borrow"}, int'(borrow), m_borrow);
        chk({tag, ".zero"}, int'(zero), m_zero);
        chk({tag, ".neg"}, int'(neg), m_neg);
        chk({tag, ".ovf"}, int'(ovf), m_ovf);
        chk({tag, ".out_valid"}, int'(out_valid), m_valid);
    endtask

    initial begin
        step(1, 0, 0, 0, "reset0");
        step(1, 0, 0, 0, "reset1");
        step(0, 0, 9, 3, "idle_after_reset");
        step(0, 1, 5, 3, "basic");
        step(0, 0, 1, 1, "basic_hold");
        step(0, 1, 8, 2, "ovf_mostneg");
        step(0, 1, 6, 6, "equal");
        step(0, 1, 2, 4, "negative");
        step(0, 1, 0, 1, "zero_minus_one");
        step(0, 1, 0, 8, "zero_minus_mostneg");
        step(0, 0, 3, 3, "hold2");
        for (int i = 0; i < 5; i++)
            step(0, 1, int'($urandom_range(M - 1)), int'($urandom_range(M - 1)), "stream");
        step(1, 1, 7, 1, "reset_midop");
        step(0, 0, 7, 1, "after_reset_midop");
        for (int i = 0; i < 60; i++)
            step(($urandom_range(15) == 0), $urandom_range(1), int'($urandom_range(M - 1)),
                 int'($urandom_range(M - 1)), "random");
        for (int i = 0; i < M * M; i++)
            step(0, 1, i / M, i % M, "sweep");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
